// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer that shares one shift-add multiplier among N_REQ requesters.
// Zero operands bypass the multiplier; a watchdog turns a hung operation into an error response.
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done_out,
    output logic [2*WIDTH-1:0]     product_out,
    output logic                   err_out,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_ready,
    input  logic [2*WIDTH-1:0]     mul_product
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESPOND} state_t;

    state_t          state_reg;
    logic [IW-1:0]   last_idx_reg;
    logic [IW-1:0]   idx_reg;
    logic [TW-1:0]   timer_reg;
    logic            err_reg;

    logic [IW-1:0]   cand [N_REQ];
    logic [IW-1:0]   pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // cand[k] is the requester k+1 positions after the last winner
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = IW'((int'(last_idx_reg) + gi + 1) % N_REQ);
        end
    endgenerate

    always_comb begin
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                pick_idx = cand[k];
            end
        end
        pick_onehot = N_REQ'(1) << pick_idx;
        sel_a       = a_in[pick_idx*WIDTH +: WIDTH];
        sel_b       = b_in[pick_idx*WIDTH +: WIDTH];
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_idx_reg <= IW'(N_REQ - 1);
            idx_reg      <= '0;
            timer_reg    <= '0;
            err_reg      <= 1'b0;
            gnt          <= '0;
            done_out     <= '0;
            product_out  <= '0;
            err_out      <= 1'b0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
        end else begin
            mul_start <= 1'b0;
            done_out  <= '0;
            err_out   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if ((|req) && mul_ready) begin
                        idx_reg <= pick_idx;
                        mul_a   <= sel_a;
                        mul_b   <= sel_b;
                        gnt     <= pick_onehot;
                        err_reg <= 1'b0;
                        if (sel_a == '0 || sel_b == '0) begin
                            product_out <= '0;
                            state_reg   <= RESPOND;
                        end else begin
                            mul_start <= 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= WAIT_ACC;
                end
                WAIT_ACC, WAIT_DONE: begin
                    timer_reg <= timer_reg + 1'b1;
                    // The watchdog wins over a completion seen in the same cycle
                    if (timer_reg == TW'(TIMEOUT - 1)) begin
                        product_out <= '0;
                        err_reg     <= 1'b1;
                        state_reg   <= RESPOND;
                    end else if (state_reg == WAIT_ACC) begin
                        if (!mul_ready) begin
                            state_reg <= WAIT_DONE;
                        end
                    end else if (mul_ready) begin
                        product_out <= mul_product;
                        state_reg   <= RESPOND;
                    end
                end
                RESPOND: begin
                    done_out     <= gnt;
                    err_out      <= err_reg;
                    gnt          <= '0;
                    last_idx_reg <= idx_reg;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed table, hand-written corner sequences and
// randomized traffic checked against a transaction-level round-robin/product model.
module tb_mult_share_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TO  = 64;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]  gnt, done_out;
    logic [2*W-1:0] product_out;
    logic          err_out, busy, mul_start;
    logic [W-1:0]  mul_a, mul_b;
    logic          mul_ready;
    logic [2*W-1:0] mul_product;

    // multiplier model: 0 normal, 1 ready stuck high, 2 ready stuck low after start
    int            mmode = 0;
    logic          m_ready = 1'b1;
    int            m_cnt = 0;
    logic [2*W-1:0] m_prod = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int starts = 0;
    bit onehot_bad = 0;
    int last = N - 1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_idx;
        logic [15:0] exp_prod;
        bit          bypass;
    } vec_t;
    vec_t tbl [8];

    mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done_out(done_out), .product_out(product_out), .err_out(err_out),
        .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    assign mul_ready   = m_ready;
    assign mul_product = m_ready ? m_prod : 16'hDEAD;

    always @(posedge clk) begin
        if (mmode == 0) begin
            if (mul_start && m_ready) begin
                m_ready <= 1'b0;
                m_cnt   <= LAT - 1;
                m_prod  <= mul_a * mul_b;
            end else if (!m_ready) begin
                if (m_cnt == 0) m_ready <= 1'b1;
                else m_cnt <= m_cnt - 1;
            end
        end else if (mmode == 1) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
        end else begin
            m_cnt <= 0;
            if (mul_start) m_ready <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mul_start) starts++;
        if ($countones(gnt) > 1) onehot_bad = 1'b1;
    endtask

    function automatic int model_pick(input logic [3:0] r, input int l);
        for (int k = 1; k <= N; k++) begin
            if (r[(l + k) % N]) return (l + k) % N;
        end
        return 0;
    endfunction

    // Waits for the grant and the done pulse of one operation and checks both ends
    task automatic do_op(input string name, input int exp_idx, input logic [15:0] exp_prod,
                         input logic exp_err, input int exp_lat, input int exp_starts,
                         input bit drop);
        int t;
        int g0;
        logic [3:0] oh;
        oh = 4'b0001 << exp_idx;
        starts = 0;
        onehot_bad = 0;
        t = 0;
        do begin tick(); t++; end while (gnt == 4'b0 && t < 40);
        chk({name, "_gnt"}, 32'(gnt), 32'(oh));
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_opnd"}, 32'({mul_a, mul_b}),
            32'({a_in[exp_idx*W +: W], b_in[exp_idx*W +: W]}));
        g0 = cyc;
        t = 0;
        do begin tick(); t++; end while (done_out == 4'b0 && t < 200);
        chk({name, "_done"}, 32'(done_out), 32'(oh));
        chk({name, "_prod"}, 32'(product_out), 32'(exp_prod));
        chk({name, "_err"}, 32'(err_out), 32'(exp_err));
        chk({name, "_lat"}, 32'(cyc - g0), 32'(exp_lat));
        chk({name, "_starts"}, 32'(starts), 32'(exp_starts));
        chk({name, "_idle"}, 32'({gnt, busy}), 32'd0);
        chk({name, "_onehot"}, 32'(onehot_bad), 32'd0);
        $display("op %s: idx=%0d product=%0d err=%0d lat=%0d", name, exp_idx,
                 product_out, err_out, cyc - g0);
        last = exp_idx;
        if (drop) req[exp_idx] = 1'b0;
    endtask

    initial begin
        logic [7:0]  ra [N];
        logic [7:0]  rb [N];
        bit          pend [N];
        logic [15:0] p;
        int          e;
        bit          seen;

        tbl[0] = '{4'b0001, 32'h0000_0003, 32'h0000_0005, 0, 16'd15,    1'b0};
        tbl[1] = '{4'b0100, 32'h0009_0000, 32'h0000_0000, 2, 16'd0,     1'b1};
        tbl[2] = '{4'b1000, 32'hFF00_0000, 32'hFF00_0000, 3, 16'd65025, 1'b0};
        tbl[3] = '{4'b0010, 32'h0000_0000, 32'h0000_4D00, 1, 16'd0,     1'b1};
        tbl[4] = '{4'b0110, 32'h00C8_0C00, 32'h0003_0B00, 2, 16'd600,   1'b0};
        tbl[5] = '{4'b0010, 32'h00C8_0C00, 32'h0003_0B00, 1, 16'd132,   1'b0};
        tbl[6] = '{4'b1001, 32'h1000_0001, 32'h1000_0001, 3, 16'd256,   1'b0};
        tbl[7] = '{4'b1001, 32'h1000_0001, 32'h1000_0001, 0, 16'd1,     1'b0};

        tick();
        tick();
        chk("rst_ctl", 32'({gnt, done_out, err_out, busy, mul_start}), 32'd0);
        chk("rst_data", 32'({product_out, mul_a, mul_b}), 32'd0);
        reset = 1'b0;

        // All four requesters held: strict rotation starting at requester 0
        req  = 4'b1111;
        a_in = {8'd4, 8'd3, 8'd2, 8'd1};
        b_in = {8'd40, 8'd30, 8'd20, 8'd10};
        for (int k = 0; k < 5; k++) begin
            e = k % N;
            p = 16'((e + 1) * (e + 1) * 10);
            do_op($sformatf("rr%0d", k), e, p, 1'b0, 3 + LAT, 1, 1'b0);
        end
        req = '0;

        for (int i = 0; i < 8; i++) begin
            req  = tbl[i].req;
            a_in = tbl[i].a;
            b_in = tbl[i].b;
            do_op($sformatf("vec%0d", i), tbl[i].exp_idx, tbl[i].exp_prod, 1'b0,
                  tbl[i].bypass ? 1 : 3 + LAT, tbl[i].bypass ? 0 : 1, 1'b1);
        end
        req = '0;

        // Watchdog: ready never drops, then ready never returns
        mmode = 1;
        req = 4'b0001; a_in = 32'h0000_0005; b_in = 32'h0000_0006;
        do_op("stuck1", 0, 16'd0, 1'b1, 2 + TO, 1, 1'b1);
        mmode = 2;
        req = 4'b0010; a_in = 32'h0000_0700; b_in = 32'h0000_0900;
        do_op("stuck0", 1, 16'd0, 1'b1, 2 + TO, 1, 1'b1);
        mmode = 0;

        // Reset in WAIT_DONE aborts silently and restores requester 0 priority
        req = 4'b0001; a_in = 32'h0000_0402; b_in = 32'h0000_0503;
        do_op("pre_rst", 0, 16'd6, 1'b0, 3 + LAT, 1, 1'b1);
        req = 4'b0010;
        e = 0;
        do begin tick(); e++; end while (gnt == 4'b0 && e < 40);
        tick(); tick(); tick();
        chk("rst_pre", 32'({busy, mul_ready}), 32'd2);
        reset = 1'b1;
        #1;
        chk("rst_async_ctl", 32'({gnt, done_out, err_out, busy, mul_start}), 32'd0);
        chk("rst_async_data", 32'({product_out, mul_a, mul_b}), 32'd0);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last = N - 1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done_out != 4'b0) seen = 1;
        end
        chk("rst_nodone", 32'(seen), 32'd0);
        req = 4'b0011;
        do_op("post_rst0", 0, 16'd6, 1'b0, 3 + LAT, 1, 1'b1);
        do_op("post_rst1", 1, 16'd20, 1'b0, 3 + LAT, 1, 1'b1);

        // Randomized traffic against the transaction-level model
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    ra[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    rb[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                end
            end
            e = $urandom_range(0, N - 1);
            if (!pend[0] && !pend[1] && !pend[2] && !pend[3]) begin
                pend[e] = 1;
                ra[e] = 8'($urandom_range(1, 255));
                rb[e] = 8'($urandom_range(1, 255));
            end
            for (int i = 0; i < N; i++) begin
                req[i] = pend[i];
                a_in[i*W +: W] = ra[i];
                b_in[i*W +: W] = rb[i];
            end
            e = model_pick(req, last);
            p = ra[e] * rb[e];
            if (ra[e] == 8'd0 || rb[e] == 8'd0)
                do_op($sformatf("rnd%0d", n), e, 16'd0, 1'b0, 1, 0, 1'b1);
            else
                do_op($sformatf("rnd%0d", n), e, p, 1'b0, 3 + LAT, 1, 1'b1);
            pend[e] = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
